// File: rtl/matrix_permute_engine.sv
// Iterative 5x5 lane-matrix permutation engine: pi, inverse pi, rho or theta
// applied once per cycle for a programmable round count, with valid/ready I/O.
module matrix_permute_engine #(
  parameter int LANE_W = 8,
  parameter int CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [25*LANE_W-1:0]  i_in_state,
  input  logic [1:0]            i_mode,
  input  logic [CNT_W-1:0]      i_rounds,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [25*LANE_W-1:0]  o_out_state,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_rounds_left
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

  localparam int RHO [25] = '{ 0,  1, 62, 28, 27,
                              36, 44,  6, 55, 20,
                               3, 10, 43, 25, 39,
                              41, 45, 15, 21,  8,
                              18,  2, 61, 56, 14};

  fsm_t                  r_fsm, w_fsm_nxt;
  logic [25*LANE_W-1:0]  r_state;
  logic [1:0]            r_mode;
  logic [CNT_W-1:0]      r_rounds_left;
  logic                  w_accept;

  logic [LANE_W-1:0]     w_a [25];
  logic [LANE_W-1:0]     w_b [25];
  logic [LANE_W-1:0]     w_c [5];
  logic [LANE_W-1:0]     w_d [5];
  logic [25*LANE_W-1:0]  w_step;

  // Rotation through a doubled copy keeps shift-by-zero and LANE_W=1 well defined.
  function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] a, input int s);
    logic [2*LANE_W-1:0] t;
    t = {a, a} << s;
    return t[2*LANE_W-1 -: LANE_W];
  endfunction

  always_comb begin
    for (int l = 0; l < 25; l++) w_a[l] = r_state[l*LANE_W +: LANE_W];
  end

  always_comb begin
    for (int x = 0; x < 5; x++) begin
      w_c[x] = '0;
      for (int y = 0; y < 5; y++) w_c[x] = w_c[x] ^ w_a[5*y+x];
    end
  end

  always_comb begin
    for (int x = 0; x < 5; x++) w_d[x] = w_c[(x+4)%5] ^ rotl(w_c[(x+1)%5], 1);
  end

  always_comb begin
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        case (r_mode)
          2'd0:    w_b[5*y+x] = w_a[5*x + (x+3*y)%5];
          2'd1:    w_b[5*y+x] = w_a[5*((2*x+3*y)%5) + y];
          2'd2:    w_b[5*y+x] = rotl(w_a[5*y+x], RHO[5*y+x] % LANE_W);
          default: w_b[5*y+x] = w_a[5*y+x] ^ w_d[x];
        endcase
      end
    end
  end

  always_comb begin
    for (int l = 0; l < 25; l++) w_step[l*LANE_W +: LANE_W] = w_b[l];
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_accept  = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (i_in_valid) begin
          w_accept  = 1'b1;
          w_fsm_nxt = (i_rounds == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (r_rounds_left == CNT_W'(1)) w_fsm_nxt = S_DONE;
      S_DONE:  if (i_out_ready) w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm         <= S_IDLE;
      r_state       <= '0;
      r_mode        <= '0;
      r_rounds_left <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (w_accept) begin
        r_state       <= i_in_state;
        r_mode        <= i_mode;
        r_rounds_left <= i_rounds;
      end else if (r_fsm == S_RUN) begin
        r_state       <= w_step;
        r_rounds_left <= r_rounds_left - CNT_W'(1);
      end
    end
  end

  // in_ready is gated by rst so it reads low for the whole reset pulse.
  assign o_in_ready    = (r_fsm == S_IDLE) && !rst;
  assign o_out_valid   = (r_fsm == S_DONE);
  assign o_busy        = (r_fsm != S_IDLE);
  assign o_out_state   = r_state;
  assign o_rounds_left = r_rounds_left;

endmodule

// File: tb/tb_matrix_permute_engine.sv
// Directed bench for matrix_permute_engine: vector table of hand-computed jobs
// plus sequences for reset, pass-through hold, pi/inverse-pi and mid-run abort.
module tb_matrix_permute_engine;

  localparam int LW = 8;
  localparam int SW = 25*LW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready;
  logic [SW-1:0] i_in_state = '0;
  logic [1:0]    i_mode = '0;
  logic [4:0]    i_rounds = '0;
  logic          o_out_valid;
  logic          i_out_ready = 1'b0;
  logic [SW-1:0] o_out_state;
  logic          o_busy;
  logic [4:0]    o_rounds_left;

  int n_checks = 0;
  int n_errors = 0;

  matrix_permute_engine #(.LANE_W(LW), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_state(i_in_state),
    .i_mode(i_mode), .i_rounds(i_rounds),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_state(o_out_state),
    .o_busy(o_busy), .o_rounds_left(o_rounds_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    mode;
    logic [4:0]    rounds;
    logic [SW-1:0] din;
    logic [SW-1:0] dexp;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [SW-1:0] lane(input int idx, input logic [7:0] v);
    logic [SW-1:0] r;
    r = '0;
    r[idx*LW +: LW] = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [SW-1:0] got, input logic [SW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic run_job(input logic [1:0] m, input logic [4:0] n, input logic [SW-1:0] s,
                         output logic [SW-1:0] res);
    int g;
    int lat;
    g = 0;
    @(negedge clk);
    while (!o_in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_before_job", SW'(o_in_ready), SW'(1));
    i_in_valid = 1'b1;
    i_in_state = s;
    i_mode     = m;
    i_rounds   = n;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_mode     = ~m;
    i_rounds   = ~n;
    i_in_state = ~s;
    chk("rounds_left_at_accept", SW'(o_rounds_left), SW'(n));
    chk("busy_at_accept", SW'(o_busy), SW'(1));
    lat = 0;
    while (!o_out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", SW'(lat), SW'(n));
    res = o_out_state;
    @(negedge clk);
    i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    i_out_ready = 1'b0;
    chk("out_valid_after_handshake", SW'(o_out_valid), SW'(0));
  endtask

  initial begin
    logic [SW-1:0] pat, pat2, res, res2;
    for (int l = 0; l < 25; l++) begin
      pat[l*LW +: LW]  = 8'(l*37 + 11);
      pat2[l*LW +: LW] = 8'(l*91 + 200);
    end

    vecs[0] = '{2'd0, 5'd1,  lane(1, 8'hA5), lane(10, 8'hA5)};
    vecs[1] = '{2'd1, 5'd1,  lane(10, 8'hA5), lane(1, 8'hA5)};
    vecs[2] = '{2'd2, 5'd1,  lane(1, 8'h01) | lane(2, 8'h01), lane(1, 8'h02) | lane(2, 8'h40)};
    vecs[3] = '{2'd2, 5'd31, lane(1, 8'h01) | lane(2, 8'h01), lane(1, 8'h80) | lane(2, 8'h04)};
    vecs[4] = '{2'd3, 5'd1,  lane(0, 8'h01),
                lane(0, 8'h01) | lane(1, 8'h01) | lane(6, 8'h01) | lane(11, 8'h01)
                | lane(16, 8'h01) | lane(21, 8'h01) | lane(4, 8'h02) | lane(9, 8'h02)
                | lane(14, 8'h02) | lane(19, 8'h02) | lane(24, 8'h02)};
    vecs[5] = '{2'd0, 5'd24, pat, pat};
    vecs[6] = '{2'd2, 5'd8,  pat, pat};
    vecs[7] = '{2'd0, 5'd0,  pat2, pat2};
    vecs[8] = '{2'd3, 5'd1,  lane(4, 8'h80),
                lane(4, 8'h80) | lane(0, 8'h80) | lane(5, 8'h80) | lane(10, 8'h80)
                | lane(15, 8'h80) | lane(20, 8'h80) | lane(3, 8'h01) | lane(8, 8'h01)
                | lane(13, 8'h01) | lane(18, 8'h01) | lane(23, 8'h01)};

    // reset state
    #12;
    chk("rst_in_ready", SW'(o_in_ready), SW'(0));
    chk("rst_out_valid", SW'(o_out_valid), SW'(0));
    chk("rst_busy", SW'(o_busy), SW'(0));
    chk("rst_rounds_left", SW'(o_rounds_left), SW'(0));
    chk("rst_out_state", o_out_state, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_release", SW'(o_in_ready), SW'(1));

    for (int i = 0; i < 9; i++) begin
      run_job(vecs[i].mode, vecs[i].rounds, vecs[i].din, res);
      chk($sformatf("vec%0d_state", i), res, vecs[i].dexp);
    end

    run_job(2'd0, 5'd1, pat, res);
    run_job(2'd1, 5'd1, res, res2);
    chk("pi_then_inv_pi", res2, pat);

    // pass-through job held under out_ready low with stray in_valid
    @(negedge clk);
    i_in_valid = 1'b1;
    i_in_state = pat2;
    i_mode     = 2'd3;
    i_rounds   = 5'd0;
    @(posedge clk);
    #1;
    chk("r0_out_valid", SW'(o_out_valid), SW'(1));
    chk("r0_out_state", o_out_state, pat2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_in_valid = 1'b1;
      i_in_state = pat ^ SW'(k);
      i_rounds   = 5'd3;
      @(posedge clk);
      #1;
      chk("hold_out_valid", SW'(o_out_valid), SW'(1));
      chk("hold_out_state", o_out_state, pat2);
      chk("hold_in_ready", SW'(o_in_ready), SW'(0));
    end
    @(negedge clk);
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    i_out_ready = 1'b0;
    chk("release_out_valid", SW'(o_out_valid), SW'(0));
    chk("release_in_ready", SW'(o_in_ready), SW'(1));
    chk("release_busy", SW'(o_busy), SW'(0));

    // abort in third RUN cycle of a 10-round job
    @(negedge clk);
    i_in_valid = 1'b1;
    i_in_state = pat;
    i_mode     = 2'd3;
    i_rounds   = 5'd10;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("pre_abort_rounds_left", SW'(o_rounds_left), SW'(8));
    rst = 1'b1;
    #1;
    chk("abort_in_ready", SW'(o_in_ready), SW'(0));
    chk("abort_out_valid", SW'(o_out_valid), SW'(0));
    chk("abort_busy", SW'(o_busy), SW'(0));
    chk("abort_rounds_left", SW'(o_rounds_left), SW'(0));
    chk("abort_out_state", o_out_state, '0);
    @(negedge clk);
    rst = 1'b0;
    run_job(vecs[2].mode, vecs[2].rounds, vecs[2].din, res);
    chk("post_abort_job", res, vecs[2].dexp);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
